rom_fetch: RTL and testbench
============================

ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 2, maximum memory reads in flight (2 only; other values unsupported).
REQ-002 Clocking: one clock; reset is asynchronous and active-low (ports CLK and RST_N).
REQ-003 CLK  in  1  sole clock; all state changes on posedge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 romAdd  in  16  instruction address (program counter) from the control unit.
REQ-006 fetchReq  in  1  one-cycle pulse: fetch the instruction at romAdd.
REQ-007 controlWord  out  32  assembled instruction: [15:0] from the even word, [31:16] from the odd word.
REQ-008 wordValid  out  1  high while controlWord holds the instruction for the last requested romAdd.
REQ-009 memAddr  out  17  program-memory word address.
REQ-010 memRead  out  1  one-cycle read strobe; memAddr is sampled with it.
REQ-011 memData  in  16  read data.
REQ-012 memValid  in  1  read-data strobe; responses return in order, latency >= 1 cycle.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 Instruction at PC p occupies memory words 2p (low half) and 2p+1 (high half); memAddr = {p,0} then {p,1}.
REQ-015 States: IDLE, REQ_LO, REQ_HI, WAIT, DRAIN.
REQ-016 IDLE + fetchReq with tagValid and romAdd == tag: hit; no memRead; wordValid rises next cycle with controlWord unchanged.
REQ-017 IDLE + fetchReq on a miss: latch romAdd into pendAddr, clear wordValid and tagValid next cycle, go to REQ_LO.
REQ-018 REQ_LO: memRead=1, memAddr={pendAddr,0}, outstanding+1, go to REQ_HI.
REQ-019 REQ_HI: memRead=1, memAddr={pendAddr,1}, outstanding+1, go to WAIT.
REQ-020 memValid in REQ_HI/WAIT: first response -> controlWord[15:0], second -> controlWord[31:16]; outstanding-1 per response.
REQ-021 Second response accepted: tag=pendAddr, tagValid=1, wordValid=1 on the next cycle, go to IDLE.
REQ-022 Total fetch latency on a miss with memory latency L: wordValid high exactly L+3 cycles after the fetchReq cycle.
REQ-023 fetchReq while busy (redirect, e.g. jump): latch the new romAdd into pendAddr; if outstanding > 0 go to DRAIN, else go to REQ_LO.
REQ-024 DRAIN: discard memValid data (controlWord untouched), decrement outstanding; on reaching 0 go to REQ_LO for pendAddr.
REQ-025 Repeated fetchReq during DRAIN: only the last romAdd is kept.
REQ-026 Same-cycle memValid and memRead: outstanding unchanged (+1-1); never exceeds MAX_OUTSTANDING.
REQ-027 memValid in IDLE/REQ_LO with outstanding == 0: ignored.
REQ-028 fetchReq has priority over completion in the same cycle: response captured/discarded per REQ-023/024, wordValid stays 0.
REQ-029 pendAddr+1 arithmetic is never needed; address 0xFFFF maps to words 0x1FFFE/0x1FFFF (17-bit, no wrap).

Reset
REQ-030 RST_N low: state=IDLE, controlWord=0, wordValid=0, tagValid=0, tag=0, pendAddr=0, outstanding=0, memRead=0, memAddr=0, busy=0.
REQ-031 Reset mid-fetch abandons in-flight reads; responses arriving after reset release are ignored per REQ-027.
REQ-032 Outputs are registered; no combinational path from fetchReq or memValid to any output.

Structure
REQ-033 Shared package holds the state encoding (3-bit localparams) and the instruction word width (32) and half width (16).
REQ-034 No sub-module; one always block for the FSM and counters, one for the data capture.

Verification
REQ-035 Reset, fetchReq romAdd=0x0010, memory L=1 returning 0x1A06/0x0005 -> memAddr 0x00020,0x00021; controlWord=0x00051A06; wordValid at cycle 4.
REQ-036 Repeat fetchReq romAdd=0x0010 -> no memRead; wordValid high next cycle; controlWord unchanged.
REQ-037 fetchReq 0x0020, then fetchReq 0x0040 in the REQ_HI cycle, L=3 -> two responses discarded; reads to 0x00080/0x00081; final controlWord from 0x0040.
REQ-038 fetchReq 0xFFFF -> memAddr 0x1FFFE then 0x1FFFF; tag=0xFFFF.
REQ-039 RST_N asserted in WAIT with one response pending, released, response arrives -> ignored; wordValid=0, controlWord=0.

Source files
------------

// File: rtl/rom_fetch_pkg.sv
// rom_fetch_pkg: shared widths, state encoding and address helper for the
// two-word instruction fetch unit.
`default_nettype none

package rom_fetch_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int PC_W   = 16;
  localparam int MEM_AW = 17;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ_LO = 3'd1;
  localparam logic [2:0] ST_REQ_HI = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    REQ_LO = ST_REQ_LO,
    REQ_HI = ST_REQ_HI,
    WAIT   = ST_WAIT,
    DRAIN  = ST_DRAIN
  } state_e;

  // Each instruction occupies two consecutive memory words: low half first.
  function automatic logic [MEM_AW-1:0] word_addr(input logic [PC_W-1:0] pc,
                                                  input logic            hi);
    return {pc, hi};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_fetch_if.sv
// rom_fetch_if: control-unit and program-memory signals of the fetch unit.
// The fetch unit uses the slave view; its environment uses the master view.
`default_nettype none

interface rom_fetch_if;
  import rom_fetch_pkg::*;

  logic [PC_W-1:0]   romAdd;
  logic              fetchReq;
  logic [WORD_W-1:0] controlWord;
  logic              wordValid;
  logic [MEM_AW-1:0] memAddr;
  logic              memRead;
  logic [HALF_W-1:0] memData;
  logic              memValid;
  logic              busy;

  modport slave (
    input  romAdd, fetchReq, memData, memValid,
    output controlWord, wordValid, memAddr, memRead, busy
  );

  modport master (
    output romAdd, fetchReq, memData, memValid,
    input  controlWord, wordValid, memAddr, memRead, busy
  );

endinterface

`default_nettype wire

// File: rtl/rom_fetch.sv
// rom_fetch: fetches a 32-bit instruction as two 16-bit memory reads, with a
// one-entry tag for repeat fetches and redirect handling that drains stale reads.
`default_nettype none

module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  rom_fetch_if.slave bus
);

  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pend_addr_q, pend_addr_d;
  logic [PC_W-1:0]     tag_q, tag_d;
  logic                tag_valid_q, tag_valid_d;
  logic                word_valid_q, word_valid_d;
  logic [OCNT_W-1:0]   outstanding_q, outstanding_d;
  logic                got_lo_q, got_lo_d;
  logic                mem_read_q, mem_read_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic [WORD_W-1:0]   control_word_q, control_word_d;

  logic                resp_ok;
  logic                collect;
  logic                hit;

  always_comb begin
    state_d        = state_q;
    pend_addr_d    = pend_addr_q;
    tag_d          = tag_q;
    tag_valid_d    = tag_valid_q;
    word_valid_d   = word_valid_q;
    got_lo_d       = got_lo_q;
    control_word_d = control_word_q;
    outstanding_d  = outstanding_q;

    // A response only counts when a read is actually in flight.
    resp_ok = bus.memValid && (outstanding_q != '0);
    collect = resp_ok && ((state_q == REQ_HI) || (state_q == WAIT));
    hit     = tag_valid_q && (bus.romAdd == tag_q);

    if (mem_read_q && !resp_ok) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!mem_read_q && resp_ok) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    if (collect) begin
      if (!got_lo_q) begin
        control_word_d[HALF_W-1:0] = bus.memData;
        got_lo_d                   = 1'b1;
      end else begin
        control_word_d[WORD_W-1:HALF_W] = bus.memData;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.fetchReq) begin
          if (hit) begin
            word_valid_d = 1'b1;
          end else begin
            pend_addr_d  = bus.romAdd;
            word_valid_d = 1'b0;
            tag_valid_d  = 1'b0;
            state_d      = REQ_LO;
          end
        end
      end
      REQ_LO: begin
        got_lo_d = 1'b0;
        state_d  = REQ_HI;
      end
      REQ_HI: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (collect && got_lo_q) begin
          tag_d        = pend_addr_q;
          tag_valid_d  = 1'b1;
          word_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = REQ_LO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect overrides any completion in the same cycle.
    if (bus.fetchReq && (state_q != IDLE)) begin
      pend_addr_d  = bus.romAdd;
      tag_d        = tag_q;
      tag_valid_d  = 1'b0;
      word_valid_d = 1'b0;
      state_d      = (outstanding_d != '0) ? DRAIN : REQ_LO;
    end

    // Strobe and address are registered from the next state.
    mem_read_d = (state_d == REQ_LO) || (state_d == REQ_HI);
    mem_addr_d = mem_addr_q;
    if (state_d == REQ_LO) begin
      mem_addr_d = word_addr(pend_addr_d, 1'b0);
    end else if (state_d == REQ_HI) begin
      mem_addr_d = word_addr(pend_addr_d, 1'b1);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      pend_addr_q   <= '0;
      tag_q         <= '0;
      tag_valid_q   <= 1'b0;
      word_valid_q  <= 1'b0;
      outstanding_q <= '0;
      got_lo_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_addr_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_addr_q   <= pend_addr_d;
      tag_q         <= tag_d;
      tag_valid_q   <= tag_valid_d;
      word_valid_q  <= word_valid_d;
      outstanding_q <= outstanding_d;
      got_lo_q      <= got_lo_d;
      mem_read_q    <= mem_read_d;
      mem_addr_q    <= mem_addr_d;
      busy_q        <= busy_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      control_word_q <= '0;
    end else begin
      control_word_q <= control_word_d;
    end
  end

  assign bus.controlWord = control_word_q;
  assign bus.wordValid   = word_valid_q;
  assign bus.memAddr     = mem_addr_q;
  assign bus.memRead     = mem_read_q;
  assign bus.busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: table vectors, redirect/reset sequences and randomized fetches
// against an in-order memory model and a transaction-level expectation model.
`default_nettype none

module tb_rom_fetch;
  import rom_fetch_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  rom_fetch_if bus ();

  rom_fetch #(.MAX_OUTSTANDING(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Program memory contents: two fixed words, everything else derived from address.
  function automatic logic [15:0] mem_word(input logic [16:0] a);
    if (a == 17'h00020) return 16'h1A06;
    if (a == 17'h00021) return 16'h0005;
    return a[15:0] + 16'h1000;
  endfunction

  function automatic logic [31:0] instr(input logic [15:0] pc);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {pc, 1'b0};
    hi = {pc, 1'b1};
    return {mem_word(hi), mem_word(lo)};
  endfunction

  typedef struct {
    int          due;
    logic [16:0] addr;
  } rsp_t;

  rsp_t        rq[$];
  logic [16:0] rd_log[$];
  int          cyc     = 0;
  int          mem_lat = 1;
  bit          mem_auto = 1'b1;

  // One clock: log reads, return in-order responses L cycles later, end fetch pulses.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    bus.fetchReq = 1'b0;
    if (bus.memRead) begin
      rd_log.push_back(bus.memAddr);
      if (mem_auto) rq.push_back('{cyc + mem_lat, bus.memAddr});
    end
    if (mem_auto) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        bus.memValid = 1'b1;
        bus.memData  = mem_word(rq[0].addr);
        void'(rq.pop_front());
      end else begin
        bus.memValid = 1'b0;
        bus.memData  = 16'h0000;
      end
    end
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.wordValid) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    int          lat;
    int          exp_n;
    int          exp_reads;
    logic [16:0] exp_a0;
    logic [31:0] exp_cw;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          n;
    logic [31:0] prev;
    logic [15:0] addr, final_addr;
    bit          m_tag_valid, hit, redir;
    logic [15:0] m_tag;
    int          lat, d, sz;

    vt[0] = '{16'h0010, 1, 4, 2, 17'h00020, 32'h00051A06};
    vt[1] = '{16'h0010, 1, 1, 0, 17'h00000, 32'h00051A06};
    vt[2] = '{16'h0011, 2, 5, 2, 17'h00022, 32'h10231022};
    vt[3] = '{16'h0010, 3, 6, 2, 17'h00020, 32'h00051A06};
    vt[4] = '{16'hFFFF, 2, 5, 2, 17'h1FFFE, 32'h0FFF0FFE};
    vt[5] = '{16'hFFFF, 1, 1, 0, 17'h00000, 32'h0FFF0FFE};
    vt[6] = '{16'h0000, 4, 7, 2, 17'h00000, 32'h10011000};

    RST_N        = 1'b0;
    bus.romAdd   = 16'h0000;
    bus.fetchReq = 1'b0;
    bus.memData  = 16'h0000;
    bus.memValid = 1'b0;
    repeat (3) tick();
    check("reset wordValid", bus.wordValid, 0);
    check("reset controlWord", bus.controlWord, 0);
    check("reset memRead", bus.memRead, 0);
    check("reset memAddr", bus.memAddr, 0);
    check("reset busy", bus.busy, 0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      mem_lat = vt[i].lat;
      rd_log.delete();
      bus.romAdd   = vt[i].addr;
      bus.fetchReq = 1'b1;
      wait_valid(n);
      check($sformatf("vec%0d latency", i), n, vt[i].exp_n);
      check($sformatf("vec%0d controlWord", i), bus.controlWord, vt[i].exp_cw);
      sz = rd_log.size();
      check($sformatf("vec%0d read count", i), sz, vt[i].exp_reads);
      if (vt[i].exp_reads == 2 && sz == 2) begin
        check($sformatf("vec%0d read lo addr", i), rd_log[0], vt[i].exp_a0);
        check($sformatf("vec%0d read hi addr", i), rd_log[1], vt[i].exp_a0 | 17'h1);
      end
      tick();
      check($sformatf("vec%0d busy after", i), bus.busy, 0);
    end

    // Redirect in the REQ_HI cycle with both reads in flight.
    mem_lat = 3;
    rd_log.delete();
    prev = bus.controlWord;
    bus.romAdd   = 16'h0020;
    bus.fetchReq = 1'b1;
    tick();
    tick();
    check("redir in REQ_HI memRead", bus.memRead, 1);
    bus.romAdd   = 16'h0040;
    bus.fetchReq = 1'b1;
    repeat (4) tick();
    check("redir drained controlWord", bus.controlWord, prev);
    check("redir restart memRead", bus.memRead, 1);
    check("redir restart memAddr", bus.memAddr, 17'h00080);
    check("redir wordValid low", bus.wordValid, 0);
    wait_valid(n);
    check("redir completion latency", n, 5);
    check("redir controlWord", bus.controlWord, 32'h10811080);
    check("redir read count", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("redir read 3", rd_log[3], 17'h00081);
    end

    // Reset while one response is still pending; the late response is ignored.
    mem_auto = 1'b0;
    bus.memValid = 1'b0;
    bus.romAdd   = 16'h0030;
    bus.fetchReq = 1'b1;
    repeat (3) tick();
    bus.memValid = 1'b1;
    bus.memData  = 16'hBEEF;
    tick();
    bus.memValid = 1'b0;
    check("pre-reset busy", bus.busy, 1);
    RST_N = 1'b0;
    #1;
    check("async reset busy", bus.busy, 0);
    check("async reset controlWord", bus.controlWord, 0);
    check("async reset memRead", bus.memRead, 0);
    tick();
    RST_N = 1'b1;
    tick();
    bus.memValid = 1'b1;
    bus.memData  = 16'hCAFE;
    tick();
    bus.memValid = 1'b0;
    tick();
    tick();
    check("late resp wordValid", bus.wordValid, 0);
    check("late resp controlWord", bus.controlWord, 0);
    check("late resp busy", bus.busy, 0);
    mem_auto = 1'b1;
    rq.delete();

    // Tag must have been invalidated by reset: this is a full miss.
    mem_lat = 1;
    rd_log.delete();
    bus.romAdd   = 16'h0040;
    bus.fetchReq = 1'b1;
    wait_valid(n);
    check("post-reset miss latency", n, 4);
    check("post-reset controlWord", bus.controlWord, instr(16'h0040));
    m_tag_valid = 1'b1;
    m_tag       = 16'h0040;

    for (int t = 0; t < 40; t++) begin
      addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0100 + 16'($urandom_range(0, 2));
      lat   = $urandom_range(1, 4);
      hit   = m_tag_valid && (addr == m_tag);
      redir = !hit && ($urandom_range(0, 2) == 0);
      final_addr = addr;
      mem_lat = lat;
      rd_log.delete();
      bus.romAdd   = addr;
      bus.fetchReq = 1'b1;
      if (redir) begin
        d = $urandom_range(1, lat + 2);
        repeat (d) tick();
        final_addr   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h0100 + 16'($urandom_range(0, 2));
        bus.romAdd   = final_addr;
        bus.fetchReq = 1'b1;
      end
      wait_valid(n);
      if (!redir) check($sformatf("rand%0d latency", t), n, hit ? 1 : lat + 3);
      else check($sformatf("rand%0d redirect completes", t), (n > 0), 1);
      check($sformatf("rand%0d controlWord", t), bus.controlWord, instr(final_addr));
      sz = rd_log.size();
      if (hit) begin
        check($sformatf("rand%0d hit no reads", t), sz, 0);
      end else if (sz >= 2) begin
        check($sformatf("rand%0d last lo read", t), rd_log[sz-2], {final_addr, 1'b0});
        check($sformatf("rand%0d last hi read", t), rd_log[sz-1], {final_addr, 1'b1});
      end else begin
        check($sformatf("rand%0d read count", t), sz, 2);
      end
      m_tag       = final_addr;
      m_tag_valid = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        prev = bus.controlWord;
        bus.memValid = 1'b1;
        bus.memData  = 16'($urandom);
        tick();
        tick();
        check($sformatf("rand%0d idle stray data", t), bus.controlWord, prev);
        check($sformatf("rand%0d idle stray busy", t), bus.busy, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
